pcie_lane_serializer: RTL and testbench
=======================================

# pcie_lane_serializer

Multi-lane, parametrised parallel-to-serial converter for the PCIe PHY TX path, the successor to the single-bit 128-bit shift serializer. It accepts parallel words over a valid/ready handshake and splits each word across `LANES` lanes. It shifts one bit per lane per clock, in either bit order. A one-entry holding buffer gives gap-free back-to-back streaming, and the block drives a defined idle level and flags underrun when no data is available.

## Interface
Parameters:
- `DATA_WIDTH`, 128, parallel input word width.
- `LANES`, 4, number of serial lanes. `DATA_WIDTH % LANES` must be 0.
- `MSB_FIRST`, 1. When 1, each lane's symbol is sent MSB first; when 0, LSB first.
- `IDLE_BIT`, 0, level driven on every lane when no word is being shifted.
- Derived: `SYM_WIDTH = DATA_WIDTH/LANES` (must be ≥ 2); `CNT_W = $clog2(SYM_WIDTH)`.

Ports:
- `clk`, in, 1. Single clock; all flops use the rising edge.
- `reset`, in, 1. Asynchronous, active-high; clears all state immediately.
- `data_in`, in, `DATA_WIDTH`. Parallel word. Lane l takes `data_in[l*SYM_WIDTH +: SYM_WIDTH]`.
- `in_valid`, in, 1. `data_in` is valid.
- `in_ready`, out, 1. The block can accept a word; equals `!buf_valid`.
- `data_out`, out, `LANES`. Serial bit per lane, registered.
- `out_valid`, out, 1. High while `data_out` carries word bits.
- `word_start`, out, 1. One-cycle pulse coinciding with bit 0 of each word.
- `underrun`, out, 1. One-cycle pulse when a word finishes and no next word is buffered.

## Operation
- Handshake: a word is accepted on a rising edge where `in_valid && in_ready`. It is written into the holding buffer and `buf_valid` is set.
- State machine has two states, IDLE and SHIFT.
  - IDLE to SHIFT: on an edge where `buf_valid` is 1. Each lane's shift register loads from the buffer, `bit_cnt` is set to 0, and `buf_valid` is cleared.
  - SHIFT, `bit_cnt < SYM_WIDTH-1`: every edge shifts each lane by one bit and increments `bit_cnt`.
  - SHIFT, `bit_cnt == SYM_WIDTH-1` (last bit), `buf_valid` = 1: reload from the buffer, set `bit_cnt` to 0, clear `buf_valid`, and stay in SHIFT.
  - SHIFT, last bit, `buf_valid` = 0: go to IDLE and pulse `underrun` in the following cycle.
- Bit order:
  - With `MSB_FIRST`=1, `data_out[l]` = lane shift register MSB, and the register shifts left.
  - With `MSB_FIRST`=0, `data_out[l]` = LSB, and the register shifts right.
- Outputs by state:
  - In IDLE: `data_out = {LANES{IDLE_BIT}}` and `out_valid` = 0.
  - In SHIFT: `out_valid` = 1.
  - `word_start` = 1 in the cycle `bit_cnt` = 0 while in SHIFT.
- The buffer cannot be written and read on the same edge, because `in_ready = !buf_valid`. Since `SYM_WIDTH` ≥ 2, upstream can always refill the buffer before the next word boundary.
- `data_in` is only sampled at the accept edge; it may change freely at other times.

## Timing
- Reset values:
  - State is IDLE, `bit_cnt` = 0, `buf_valid` = 0, and shift registers are 0.
  - Outputs: `data_out = {LANES{IDLE_BIT}}`, `out_valid` = 0, `word_start` = 0, `underrun` = 0, `in_ready` = 1.
- Reset asserted mid-word: outputs take their reset values asynchronously. The buffered word and the in-flight word are discarded.
- Latency from IDLE: accept edge N, load edge N+1. Bit 0 appears on `data_out` in the cycle after N+1, with `word_start` = 1.
- Streaming: a word occupies exactly `SYM_WIDTH` consecutive cycles per lane.
  - With the buffer refilled in time, there are no gap cycles and `out_valid` stays 1.
  - Throughput is one word per `SYM_WIDTH` cycles.
- `in_ready` rises the cycle after each buffer-to-shift transfer.
- `underrun` is high for exactly one cycle, namely the first IDLE cycle after the last bit.
- `underrun` never asserts after reset unless at least one word has been sent.

## Test plan
All scenarios use `DATA_WIDTH`=16, `LANES`=2 (`SYM_WIDTH`=8) unless noted.
- Single word 0xA5C3, `MSB_FIRST`=1:
  - Lane 0 outputs 1,1,0,0,0,0,1,1.
  - Lane 1 outputs 1,0,1,0,0,1,0,1.
  - `word_start` pulses once; `underrun` pulses in cycle 9; then `data_out` = 2'b00.
- Same word with `MSB_FIRST`=0: lane 0 outputs 1,1,0,0,0,0,1,1 reversed (i.e. 1,1,0,0,0,0,1,1 read from LSB) and lane 1 outputs 1,0,1,0,0,1,0,1.
- Back-to-back 0xFFFF then 0x0000, second word offered as soon as `in_ready` rises:
  - 16 consecutive `out_valid` cycles: 8 ones then 8 zeros on both lanes.
  - Two `word_start` pulses 8 cycles apart; one `underrun` at the end.
- Backpressure: hold `in_valid` = 1 with three words. `in_ready` drops after each accept, and exactly three words are serialized in order with no duplication.
- Reset asserted at bit 3 of a word, with a second word buffered:
  - Outputs are immediately `data_out = {LANES{IDLE_BIT}}` (IDLE_BIT = 1 → 2'b11), `out_valid` = 0, `in_ready` = 1.
  - After release, nothing is emitted until a new word is accepted.
- `DATA_WIDTH`=128, `LANES`=4: an incrementing-byte word serializes in exactly 32 cycles, and each lane matches its 32-bit slice.

Source files
------------

// File: rtl/pcie_lane_serializer.sv
// pcie_lane_serializer: multi-lane parallel-to-serial converter with a one-word holding buffer.
module pcie_lane_serializer #(
    parameter int DATA_WIDTH = 128,
    parameter int LANES      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_BIT   = 1'b0,
    localparam int SYM_WIDTH = DATA_WIDTH / LANES,
    localparam int CNT_W     = $clog2(SYM_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LANES-1:0]      data_out,
    output logic                  out_valid,
    output logic                  word_start,
    output logic                  underrun
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_WIDTH - 1);
    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                bit_cnt_q, bit_cnt_d;
    logic [LANES-1:0][SYM_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0]           buf_q, buf_d;
    logic                            buf_valid_q, buf_valid_d;
    logic                            underrun_q, underrun_d;
    logic                            last_bit, load;

    assign in_ready   = !buf_valid_q;
    assign out_valid  = state_q == SHIFT;
    assign word_start = state_q == SHIFT && bit_cnt_q == '0;
    assign underrun   = underrun_q;
    assign last_bit   = bit_cnt_q == LAST;
    // Reload happens from IDLE or on the last bit so words stream without gaps.
    assign load       = buf_valid_q && (state_q == IDLE || last_bit);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        underrun_d  = 1'b0;
        if (in_valid && in_ready) begin
            buf_d       = data_in;
            buf_valid_d = 1'b1;
        end
        if (load) begin
            state_d     = SHIFT;
            bit_cnt_d   = '0;
            sr_d        = buf_q;
            buf_valid_d = 1'b0;
        end else if (state_q == SHIFT && last_bit) begin
            state_d    = IDLE;
            underrun_d = 1'b1;
        end else if (state_q == SHIFT) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            for (int l = 0; l < LANES; l++)
                sr_d[l] = MSB_FIRST ? {sr_q[l][SYM_WIDTH-2:0], 1'b0} : {1'b0, sr_q[l][SYM_WIDTH-1:1]};
        end
    end

    always_comb begin
        data_out = {LANES{IDLE_BIT}};
        if (state_q == SHIFT)
            for (int l = 0; l < LANES; l++)
                data_out[l] = MSB_FIRST ? sr_q[l][SYM_WIDTH-1] : sr_q[l][0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            underrun_q  <= underrun_d;
        end
    end
endmodule

// File: tb/tb_pcie_lane_serializer.sv
// tb_pcie_lane_serializer: directed scenarios on three serializer configurations.
module tb_pcie_lane_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [15:0]  d0 = '0, d1 = '0;
    logic [127:0] d2 = '0;
    logic         v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic         rdy0, rdy1, rdy2, ov0, ov1, ov2, ws0, ws1, ws2, ur0, ur1, ur2;
    logic [1:0]   do0, do1;
    logic [3:0]   do2;

    always #5 clk = ~clk;

    pcie_lane_serializer #(.DATA_WIDTH(16), .LANES(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
        .clk(clk), .reset(rst), .data_in(d0), .in_valid(v0), .in_ready(rdy0),
        .data_out(do0), .out_valid(ov0), .word_start(ws0), .underrun(ur0));
    pcie_lane_serializer #(.DATA_WIDTH(16), .LANES(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u1 (
        .clk(clk), .reset(rst), .data_in(d1), .in_valid(v1), .in_ready(rdy1),
        .data_out(do1), .out_valid(ov1), .word_start(ws1), .underrun(ur1));
    pcie_lane_serializer #(.DATA_WIDTH(128), .LANES(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u2 (
        .clk(clk), .reset(rst), .data_in(d2), .in_valid(v2), .in_ready(rdy2),
        .data_out(do2), .out_valid(ov2), .word_start(ws2), .underrun(ur2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vectors below are {data_out, out_valid, word_start, underrun, in_ready}.
    task automatic test_reset();
        tick();
        tick();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({do0, ov0, ws0, ur0, rdy0} !== 6'b00_0001) begin
                errors++;
                $display("FAIL reset_u0 phase %0d got %b exp 000001", p, {do0, ov0, ws0, ur0, rdy0});
            end
            checks++;
            if ({do1, ov1, ws1, ur1, rdy1} !== 6'b11_0001) begin
                errors++;
                $display("FAIL reset_u1 phase %0d got %b exp 110001", p, {do1, ov1, ws1, ur1, rdy1});
            end
            checks++;
            if ({do2, ov2, ws2, ur2, rdy2} !== 8'b0000_0001) begin
                errors++;
                $display("FAIL reset_u2 phase %0d got %b exp 00000001", p, {do2, ov2, ws2, ur2, rdy2});
            end
            rst = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_single_msb();
        logic [7:0] s0 = 8'b11000011;
        logic [7:0] s1 = 8'b10100101;
        logic [5:0] e;
        d0 = 16'hA5C3;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        checks++;
        if ({ov0, rdy0} !== 2'b00) begin
            errors++;
            $display("FAIL msb_accept got %b exp 00", {ov0, rdy0});
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            e = {s1[7-i], s0[7-i], 1'b1, i == 0, 1'b0, 1'b1};
            checks++;
            if ({do0, ov0, ws0, ur0, rdy0} !== e) begin
                errors++;
                $display("FAIL msb_bit%0d got %b exp %b", i, {do0, ov0, ws0, ur0, rdy0}, e);
            end
            tick();
        end
        checks++;
        if ({do0, ov0, ws0, ur0, rdy0} !== 6'b00_0011) begin
            errors++;
            $display("FAIL msb_underrun got %b exp 000011", {do0, ov0, ws0, ur0, rdy0});
        end
        tick();
        checks++;
        if ({do0, ov0, ws0, ur0, rdy0} !== 6'b00_0001) begin
            errors++;
            $display("FAIL msb_idle got %b exp 000001", {do0, ov0, ws0, ur0, rdy0});
        end
    endtask

    task automatic test_single_lsb();
        logic [7:0] s0 = 8'b11000011;
        logic [7:0] s1 = 8'b10100101;
        logic [5:0] e;
        d1 = 16'hA5C3;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            e = {s1[i], s0[i], 1'b1, i == 0, 1'b0, 1'b1};
            checks++;
            if ({do1, ov1, ws1, ur1, rdy1} !== e) begin
                errors++;
                $display("FAIL lsb_bit%0d got %b exp %b", i, {do1, ov1, ws1, ur1, rdy1}, e);
            end
            tick();
        end
        checks++;
        if ({do1, ov1, ws1, ur1, rdy1} !== 6'b11_0011) begin
            errors++;
            $display("FAIL lsb_underrun got %b exp 110011", {do1, ov1, ws1, ur1, rdy1});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        d0 = 16'hFFFF;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            e = {(i < 8) ? 2'b11 : 2'b00, 1'b1, i == 0 || i == 8, 1'b0, i == 0 || i >= 8};
            checks++;
            if ({do0, ov0, ws0, ur0, rdy0} !== e) begin
                errors++;
                $display("FAIL b2b_cycle%0d got %b exp %b", i, {do0, ov0, ws0, ur0, rdy0}, e);
            end
            if (i == 0) begin
                d0 = 16'h0000;
                v0 = 1'b1;
            end
            if (i == 1) v0 = 1'b0;
            tick();
        end
        checks++;
        if ({do0, ov0, ws0, ur0, rdy0} !== 6'b00_0011) begin
            errors++;
            $display("FAIL b2b_underrun got %b exp 000011", {do0, ov0, ws0, ur0, rdy0});
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] w[3] = '{16'h1234, 16'h5678, 16'h9ABC};
        logic [23:0] c0 = '0, c1 = '0;
        int idx = 0, nbits = 0, nws = 0, nur = 0;
        logic acc;
        d0 = w[0];
        v0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            acc = v0 && rdy0;
            tick();
            if (ov0) begin
                c0 = {c0[22:0], do0[0]};
                c1 = {c1[22:0], do0[1]};
                nbits++;
            end
            nws += int'(ws0);
            nur += int'(ur0);
            if (acc) begin
                checks++;
                if (rdy0 !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready_drop word %0d got %b exp 0", idx, rdy0);
                end
                idx++;
                if (idx == 3) v0 = 1'b0;
                else d0 = w[idx];
            end
        end
        v0 = 1'b0;
        checks++;
        if (nbits !== 24 || idx !== 3) begin
            errors++;
            $display("FAIL bp_count got bits %0d words %0d exp bits 24 words 3", nbits, idx);
        end
        checks++;
        if ({c1, c0} !== {24'h12569A, 24'h3478BC}) begin
            errors++;
            $display("FAIL bp_data got %h %h exp 12569a 3478bc", c1, c0);
        end
        checks++;
        if (nws !== 3 || nur !== 1) begin
            errors++;
            $display("FAIL bp_pulses got ws %0d ur %0d exp ws 3 ur 1", nws, nur);
        end
    endtask

    task automatic test_reset_mid_word();
        d1 = 16'h1234;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        tick();
        d1 = 16'h5678;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_buffered got %b exp 0", rdy1);
        end
        tick();
        tick();
        checks++;
        if ({do1, ov1, ws1, ur1, rdy1} !== 6'b00_1000) begin
            errors++;
            $display("FAIL rst_bit3 got %b exp 001000", {do1, ov1, ws1, ur1, rdy1});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({do1, ov1, ws1, ur1, rdy1} !== 6'b11_0001) begin
            errors++;
            $display("FAIL rst_async got %b exp 110001", {do1, ov1, ws1, ur1, rdy1});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({do1, ov1, ur1} !== 4'b1100) begin
                errors++;
                $display("FAIL rst_quiet cycle %0d got %b exp 1100", i, {do1, ov1, ur1});
            end
        end
        d1 = 16'h00FF;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        tick();
        checks++;
        if ({do1, ov1, ws1, ur1, rdy1} !== 6'b01_1101) begin
            errors++;
            $display("FAIL rst_new_word got %b exp 011101", {do1, ov1, ws1, ur1, rdy1});
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_wide();
        logic [31:0] c[4] = '{default: '0};
        logic [31:0] e[4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        int n = 0, nws = 0, nur = 0;
        d2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        v2 = 1'b1;
        tick();
        v2 = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (ov2) begin
                for (int l = 0; l < 4; l++) c[l] = {c[l][30:0], do2[l]};
                n++;
            end
            nws += int'(ws2);
            nur += int'(ur2);
            tick();
        end
        checks++;
        if (n !== 32 || nws !== 1 || nur !== 1) begin
            errors++;
            $display("FAIL wide_count got bits %0d ws %0d ur %0d exp 32 1 1", n, nws, nur);
        end
        for (int l = 0; l < 4; l++) begin
            checks++;
            if (c[l] !== e[l]) begin
                errors++;
                $display("FAIL wide_lane%0d got %h exp %h", l, c[l], e[l]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_msb();
        test_single_lsb();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
